me_fetch_scheduler: RTL and testbench

Shares the single 64-bit external pixel read channel between the current-frame block buffer and the previous-frame (search-window) buffer, one burst at a time. It also sequences one frame of 8x8-block motion estimation, 480 columns by 270 rows for 4K. It sits between the memory interface and the two frame buffers. It grants bursts round-robin, returns read data to the winning buffer, tracks the block position, and signals the end of the frame.

---
 rtl/me_fetch_scheduler_if.sv | 28 ++
 rtl/me_fetch_scheduler.sv | 147 ++++++++++++++
 tb/tb_me_fetch_scheduler.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/me_fetch_scheduler_if.sv
// Burst request/grant, memory command/data and routed read-data signals
// shared between the fetch scheduler, the two frame buffers and the memory port.
interface me_fetch_scheduler_if;
  logic        req_pre;
  logic        req_cur;
  logic [4:0]  len_pre;
  logic [4:0]  len_cur;
  logic        grant_pre;
  logic        grant_cur;
  logic        valid_pre;
  logic        valid_cur;
  logic [63:0] data_out;
  logic        mem_req;
  logic [4:0]  mem_len;
  logic        mem_ready;
  logic        mem_valid;
  logic [63:0] mem_data;

  modport master (
    input  req_pre, req_cur, len_pre, len_cur, mem_ready, mem_valid, mem_data,
    output grant_pre, grant_cur, valid_pre, valid_cur, data_out, mem_req, mem_len
  );

  modport slave (
    output req_pre, req_cur, len_pre, len_cur, mem_ready, mem_valid, mem_data,
    input  grant_pre, grant_cur, valid_pre, valid_cur, data_out, mem_req, mem_len
  );
endinterface

// File: rtl/me_fetch_scheduler.sv
// Round-robin burst scheduler for the shared 64-bit pixel read channel; also
// walks the 8x8 block position across one frame and flags frame completion.
module me_fetch_scheduler #(
  parameter int COLS = 480,
  parameter int ROWS = 270
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_frame_go,
  me_fetch_scheduler_if.master  bus,
  output logic                  o_busy,
  output logic                  o_frame_end,
  output logic [8:0]            o_col_idx,
  output logic [8:0]            o_row_idx
);

  typedef enum logic [2:0] {IDLE, ARB, ISSUE, XFER, DONE} state_t;

  localparam logic [8:0] LAST_COL = 9'(COLS - 1);
  localparam logic [8:0] LAST_ROW = 9'(ROWS - 1);

  state_t      r_state;
  logic        r_owner_cur;
  logic        r_last_cur;
  logic [4:0]  r_len;
  logic [4:0]  r_beat_cnt;
  logic        r_mem_req;
  logic [4:0]  r_mem_len;
  logic        r_grant_pre;
  logic        r_grant_cur;
  logic        r_valid_pre;
  logic        r_valid_cur;
  logic [63:0] r_data;
  logic        r_busy;
  logic        r_frame_end;
  logic [8:0]  r_col;
  logic [8:0]  r_row;

  logic w_any_req;
  logic w_pick_cur;
  logic w_last_beat;
  logic w_last_col;
  logic w_last_row;

  // With both requesting, the buffer that did not win last time goes next.
  assign w_any_req   = bus.req_pre | bus.req_cur;
  assign w_pick_cur  = bus.req_cur & (~bus.req_pre | ~r_last_cur);
  assign w_last_beat = bus.mem_valid & (r_beat_cnt == r_len);
  assign w_last_col  = (r_col == LAST_COL);
  assign w_last_row  = (r_row == LAST_ROW);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_owner_cur <= 1'b0;
      r_last_cur  <= 1'b1;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_len   <= '0;
      r_grant_pre <= 1'b0;
      r_grant_cur <= 1'b0;
      r_valid_pre <= 1'b0;
      r_valid_cur <= 1'b0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_frame_end <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
    end else begin
      r_grant_pre <= 1'b0;
      r_grant_cur <= 1'b0;
      r_valid_pre <= 1'b0;
      r_valid_cur <= 1'b0;
      r_frame_end <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= i_frame_go;
          if (i_frame_go) begin
            r_state    <= ARB;
            r_col      <= '0;
            r_row      <= '0;
            r_last_cur <= 1'b1;
          end
        end
        ARB: begin
          if (w_any_req) begin
            r_grant_cur <= w_pick_cur;
            r_grant_pre <= ~w_pick_cur;
            r_owner_cur <= w_pick_cur;
            r_last_cur  <= w_pick_cur;
            r_len       <= w_pick_cur ? bus.len_cur : bus.len_pre;
            r_mem_len   <= w_pick_cur ? bus.len_cur : bus.len_pre;
            r_mem_req   <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            r_mem_req  <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= XFER;
          end
        end
        XFER: begin
          if (bus.mem_valid) begin
            r_data      <= bus.mem_data;
            r_valid_cur <= r_owner_cur;
            r_valid_pre <= ~r_owner_cur;
            r_beat_cnt  <= r_beat_cnt + 5'd1;
          end
          if (w_last_beat) begin
            r_state <= ARB;
            if (r_owner_cur) begin
              if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + 9'd1;
                if (w_last_row) r_state <= DONE;
              end else begin
                r_col <= r_col + 9'd1;
              end
            end
          end
        end
        DONE: begin
          // busy stays up through the frame_end cycle and drops from IDLE.
          r_frame_end <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_len   = r_mem_len;
  assign bus.grant_pre = r_grant_pre;
  assign bus.grant_cur = r_grant_cur;
  assign bus.valid_pre = r_valid_pre;
  assign bus.valid_cur = r_valid_cur;
  assign bus.data_out  = r_data;
  assign o_busy        = r_busy;
  assign o_frame_end   = r_frame_end;
  assign o_col_idx     = r_col;
  assign o_row_idx     = r_row;

endmodule

// File: tb/tb_me_fetch_scheduler.sv
// Bench for me_fetch_scheduler with a small 4x2 frame: table of bursts plus
// hand-written frame-end and reset-mid-burst sequences, beats checked by a scoreboard.
module tb_me_fetch_scheduler;
  localparam int COLS = 4;
  localparam int ROWS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_go = 1'b0;
  logic       busy;
  logic       frame_end;
  logic [8:0] col_idx;
  logic [8:0] row_idx;

  me_fetch_scheduler_if bus();

  me_fetch_scheduler #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_frame_go (frame_go),
    .bus        (bus),
    .o_busy     (busy),
    .o_frame_end(frame_end),
    .o_col_idx  (col_idx),
    .o_row_idx  (row_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_count = 0;

  typedef struct {
    logic        cur;
    logic [63:0] data;
  } beat_t;
  beat_t sb[$];
  beat_t mon_e;

  typedef struct {
    logic       rp;
    logic       rc;
    logic [4:0] lp;
    logic [4:0] lc;
    int         stall;
    logic       exp_cur;
    logic [8:0] exp_col;
    logic [8:0] exp_row;
  } vec_t;
  vec_t vt[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Every routed beat must match the oldest expected beat in owner and data.
  always @(negedge clk) begin
    if (frame_end === 1'b1) fe_count++;
    if (bus.valid_pre === 1'b1 || bus.valid_cur === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'({bus.valid_pre, bus.valid_cur}), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("beat_owner", 64'({bus.valid_pre, bus.valid_cur}), mon_e.cur ? 64'd1 : 64'd2);
        check("beat_data", bus.data_out, mon_e.data);
      end
    end
  end

  task automatic run_burst(input logic rp, input logic rc, input logic [4:0] lp,
                           input logic [4:0] lc, input int stall, input logic exp_cur,
                           input int abort_beat);
    logic [4:0] wl;
    bit         granted;
    beat_t      e;
    granted = 1'b0;
    bus.req_pre = rp;
    bus.req_cur = rc;
    bus.len_pre = lp;
    bus.len_cur = lc;
    bus.mem_ready = 1'b0;
    bus.mem_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.grant_pre === 1'b1 || bus.grant_cur === 1'b1) begin
        granted = 1'b1;
        break;
      end
    end
    if (!granted) begin
      check("grant_timeout", 64'd0, 64'd1);
      bus.req_pre = 1'b0;
      bus.req_cur = 1'b0;
      return;
    end
    check("grant_owner", 64'({bus.grant_pre, bus.grant_cur}), exp_cur ? 64'd1 : 64'd2);
    wl = exp_cur ? lc : lp;
    if (exp_cur) bus.req_cur = 1'b0;
    else bus.req_pre = 1'b0;
    check("issue_req", 64'(bus.mem_req), 64'd1);
    check("issue_len", 64'(bus.mem_len), 64'(wl));
    for (int s = 0; s < stall; s++) begin
      // Beats offered before the handshake must be dropped.
      bus.mem_valid = 1'b1;
      bus.mem_data = {$urandom, $urandom};
      tick();
      check("stall_req", 64'(bus.mem_req), 64'd1);
      check("stall_len", 64'(bus.mem_len), 64'(wl));
    end
    bus.mem_valid = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check("req_drop", 64'(bus.mem_req), 64'd0);
    check("grant_pulse", 64'({bus.grant_pre, bus.grant_cur}), 64'd0);
    for (int b = 0; b <= int'(wl); b++) begin
      if (b == abort_beat) begin
        reset = 1'b0;
        frame_go = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_data = {$urandom, $urandom};
        tick();
        bus.mem_valid = 1'b0;
        bus.req_pre = 1'b0;
        bus.req_cur = 1'b0;
        return;
      end
      bus.mem_valid = 1'b1;
      bus.mem_data = {$urandom, $urandom};
      frame_go = (b == 0);
      e.cur = exp_cur;
      e.data = bus.mem_data;
      sb.push_back(e);
      tick();
    end
    bus.mem_valid = 1'b0;
    frame_go = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_pre = 1'b0;
    bus.req_cur = 1'b0;
    bus.len_pre = '0;
    bus.len_cur = '0;
    bus.mem_ready = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_data = '0;

    vt[0]  = '{1'b0, 1'b1, 5'd0,  5'd7, 0, 1'b1, 9'd1, 9'd0};
    vt[1]  = '{1'b1, 1'b1, 5'd3,  5'd3, 0, 1'b0, 9'd1, 9'd0};
    vt[2]  = '{1'b1, 1'b1, 5'd3,  5'd3, 0, 1'b1, 9'd2, 9'd0};
    vt[3]  = '{1'b1, 1'b1, 5'd3,  5'd3, 0, 1'b0, 9'd2, 9'd0};
    vt[4]  = '{1'b0, 1'b1, 5'd0,  5'd5, 5, 1'b1, 9'd3, 9'd0};
    vt[5]  = '{1'b1, 1'b0, 5'd2,  5'd0, 1, 1'b0, 9'd3, 9'd0};
    vt[6]  = '{1'b0, 1'b1, 5'd0,  5'd0, 0, 1'b1, 9'd0, 9'd1};
    vt[7]  = '{1'b1, 1'b1, 5'd31, 5'd1, 0, 1'b0, 9'd0, 9'd1};
    vt[8]  = '{1'b1, 1'b1, 5'd1,  5'd1, 2, 1'b1, 9'd1, 9'd1};
    vt[9]  = '{1'b0, 1'b1, 5'd0,  5'd2, 0, 1'b1, 9'd2, 9'd1};
    vt[10] = '{1'b1, 1'b1, 5'd2,  5'd2, 0, 1'b0, 9'd2, 9'd1};
    vt[11] = '{1'b1, 1'b1, 5'd2,  5'd2, 0, 1'b1, 9'd3, 9'd1};

    reset = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_end", 64'(frame_end), 64'd0);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_grants", 64'({bus.grant_pre, bus.grant_cur}), 64'd0);
    check("rst_pos", 64'({col_idx, row_idx}), 64'd0);
    reset = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    frame_go = 1'b1;
    tick();
    frame_go = 1'b0;
    check("go_busy", 64'(busy), 64'd1);

    // mem_valid while arbitrating with no requests is ignored.
    bus.mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.mem_data = {$urandom, $urandom};
      tick();
      check("arb_idle_req", 64'({bus.mem_req, bus.grant_pre, bus.grant_cur}), 64'd0);
    end
    bus.mem_valid = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_burst(vt[i].rp, vt[i].rc, vt[i].lp, vt[i].lc, vt[i].stall, vt[i].exp_cur, -1);
      check($sformatf("vec%0d_col", i), 64'(col_idx), 64'(vt[i].exp_col));
      check($sformatf("vec%0d_row", i), 64'(row_idx), 64'(vt[i].exp_row));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
    end

    // Eighth cur burst is the last block of the 4x2 frame.
    run_burst(1'b0, 1'b1, 5'd0, 5'd1, 0, 1'b1, -1);
    check("done_fe_n1", 64'(frame_end), 64'd0);
    check("done_busy_n1", 64'(busy), 64'd1);
    tick();
    check("done_fe_n2", 64'(frame_end), 64'd1);
    check("done_busy_n2", 64'(busy), 64'd1);
    tick();
    check("done_fe_n3", 64'(frame_end), 64'd0);
    check("done_busy_n3", 64'(busy), 64'd0);
    tick();
    check("fe_count", 64'(fe_count), 64'd1);

    // New frame, one block, then reset during beat 3 of an 8-beat burst.
    frame_go = 1'b1;
    tick();
    frame_go = 1'b0;
    check("go2_pos", 64'({col_idx, row_idx}), 64'd0);
    run_burst(1'b0, 1'b1, 5'd0, 5'd0, 0, 1'b1, -1);
    check("go2_col", 64'(col_idx), 64'd1);
    run_burst(1'b0, 1'b1, 5'd0, 5'd7, 0, 1'b1, 3);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'({bus.valid_pre, bus.valid_cur}), 64'd0);
    check("mid_rst_data", bus.data_out, 64'd0);
    check("mid_rst_pos", 64'({col_idx, row_idx}), 64'd0);
    check("mid_rst_cmd", 64'({bus.mem_req, bus.mem_len, frame_end}), 64'd0);
    reset = 1'b1;
    bus.mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mem_data = {$urandom, $urandom};
      tick();
      check("post_rst_busy", 64'(busy), 64'd0);
    end
    bus.mem_valid = 1'b0;
    tick();
    tick();
    check("sb_drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
